sparce_skip_redirect: RTL and testbench
=======================================

# sparce_skip_redirect

Pipeline-side responder for skip requests issued by the SparCE sparsity unit. Accepts a skip request (sparse instruction PC plus skip target), waits for any in-flight instruction fetch to drain, then issues a one-shot fetch redirect and IF/ID flush. Keeps a saturating count of skipped instructions. Sits between the sparsity unit and the fetch stage / hazard unit.

## Interface
- ADDR_WIDTH, 32, width of PCs and targets
- CNT_WIDTH, 32, width of skipped-instruction counter
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- skip_req  in  1  sparsity unit requests a skip; held with stable payload until skip_ack
- skip_origin  in  ADDR_WIDTH  PC of the sparse (condition-producing) instruction
- skip_target  in  ADDR_WIDTH  PC to resume fetch at
- imem_busy  in  1  fetch has an instruction memory request in flight
- redirect_ready  in  1  fetch stage can accept a redirect this cycle
- pipe_flush  in  1  higher-priority flush (branch/exception) from hazard unit
- skip_ack  out  1  one-cycle pulse: current request consumed
- skip_taken  out  1  qualifies skip_ack: 1 = redirect issued, 0 = dropped/rejected
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  ADDR_WIDTH  new fetch PC, valid with redirect_valid
- flush_if_id  out  1  flush IF/ID latch; equals redirect_valid && redirect_ready
- skip_count  out  CNT_WIDTH  saturating total of instructions skipped

## Operation
- States: IDLE, DRAIN, REDIRECT. Payload (origin, target) latched on leaving IDLE.
- Validity check (on skip_req in IDLE): target word-aligned (low 2 bits 0) and target > origin + 4 (unsigned). Otherwise reject.
- IDLE:
  - pipe_flush=1 and skip_req=1: ack, taken=0, stay IDLE. pipe_flush always wins.
  - skip_req=1, invalid: ack, taken=0, stay IDLE.
  - skip_req=1, valid, imem_busy=1: latch, -> DRAIN.
  - skip_req=1, valid, imem_busy=0: latch, -> REDIRECT.
- DRAIN: pipe_flush=1 -> ack taken=0, -> IDLE; else imem_busy=0 -> REDIRECT; else stay.
- REDIRECT: redirect_valid=1, redirect_pc=latched target.
  - pipe_flush=1 -> redirect_valid forced 0, ack taken=0, -> IDLE.
  - redirect_ready=1 -> flush_if_id=1, ack taken=1, -> IDLE; skip_count += ((target - origin) >> 2) - 1, saturating at all-ones.
  - redirect_ready=0 -> hold, redirect_pc stable.
- skip_ack/skip_taken/redirect_valid/flush_if_id are combinational from state and inputs; skip_count registered.
- Sparsity unit drops skip_req the cycle after skip_ack; a request present in IDLE the cycle after an ack is a new request.
- Arithmetic in ADDR_WIDTH bits; skip delta zero-extended/truncated to CNT_WIDTH before saturating add.

## Timing
- Reset (async, nRST=0): state IDLE, latched payload 0, skip_count 0; all pulse outputs 0, redirect_pc 0.
- Best case: skip_req at cycle N (IDLE, imem_busy=0) -> redirect_valid cycle N+1; with redirect_ready=1, ack and flush_if_id at N+1, skip_count updated visible N+2.
- Each DRAIN cycle and each redirect_ready=0 cycle adds one cycle of latency.
- Reject/drop in IDLE: ack same cycle as request (0-cycle latency), no redirect.
- At most one request in service; skip_req ignored outside IDLE.
- Reset mid-DRAIN/REDIRECT: immediate return to IDLE, no ack, no count update.

## Test plan
- Basic skip: origin 0x100, target 0x110, imem_busy=0, ready=1 -> redirect_pc 0x110 at N+1, ack taken=1, skip_count 0 -> 3.
- Drain: same request, imem_busy=1 for 3 cycles -> redirect_valid first at N+4, no earlier flush_if_id.
- Backpressure/flush race: in REDIRECT with ready=0 for 2 cycles then pipe_flush=1 -> redirect_pc held 0x110, then ack taken=0, count unchanged, IDLE.
- Reject: target 0x102 (misaligned) and separately target 0x104 with origin 0x100 -> immediate ack taken=0, no redirect.
- Saturation: CNT_WIDTH=4, count at 14, skip of 3 -> count 15, stays 15 on further skips.
- Async reset asserted mid-DRAIN -> outputs zero immediately, next request serviced normally from IDLE.

Source files
------------

// File: rtl/sparce_skip_redirect.sv
// sparce_skip_redirect
// Services skip requests from the SparCE sparsity unit: validates the skip,
// waits for any in-flight instruction fetch to drain, then issues a one-shot
// fetch redirect plus IF/ID flush. Keeps a saturating count of skipped
// instructions. A flush from the hazard unit always cancels a pending skip.
module sparce_skip_redirect #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  skip_req,
    input  logic [ADDR_WIDTH-1:0] skip_origin,
    input  logic [ADDR_WIDTH-1:0] skip_target,
    input  logic                  imem_busy,
    input  logic                  redirect_ready,
    input  logic                  pipe_flush,
    output logic                  skip_ack,
    output logic                  skip_taken,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush_if_id,
    output logic [CNT_WIDTH-1:0]  skip_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_origin;
    logic [ADDR_WIDTH-1:0]   r_target;
    logic [CNT_WIDTH-1:0]    r_count;

    logic [ADDR_WIDTH-1:0]   w_origin_p4;
    logic                    w_req_valid;
    logic                    w_accept;
    logic                    w_taken;
    logic [ADDR_WIDTH-1:0]   w_span;
    logic [ADDR_WIDTH-1:0]   w_delta;
    logic [CNT_WIDTH-1:0]    w_delta_c;
    logic [CNT_WIDTH:0]      w_sum;

    // A skip must land on a word boundary strictly beyond the next instruction,
    // otherwise there is nothing to skip and the request is rejected.
    assign w_origin_p4 = skip_origin + ADDR_WIDTH'(4);
    assign w_req_valid = (skip_target[1:0] == 2'b00) && (skip_target > w_origin_p4);

    // Request is taken into service (payload latched) only from IDLE.
    assign w_accept = (r_state == IDLE) && skip_req && !pipe_flush && w_req_valid;

    // Redirect handed off to fetch this cycle.
    assign w_taken = (r_state == REDIRECT) && !pipe_flush && redirect_ready;

    // Instructions skipped = words between origin and target, minus the
    // fall-through slot; resized to the counter width before the add.
    assign w_span    = r_target - r_origin;
    assign w_delta   = (w_span >> 2) - ADDR_WIDTH'(1);
    assign w_delta_c = CNT_WIDTH'(w_delta);
    assign w_sum     = {1'b0, r_count} + {1'b0, w_delta_c};

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; pipe_flush pre-empts everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = imem_busy ? DRAIN : REDIRECT;
            end
            DRAIN: begin
                if (pipe_flush)      w_state_nxt = IDLE;
                else if (!imem_busy) w_state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (pipe_flush || redirect_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake and redirect outputs, combinational from state and inputs
    always_comb begin
        skip_ack       = 1'b0;
        skip_taken     = 1'b0;
        redirect_valid = 1'b0;
        flush_if_id    = 1'b0;
        case (r_state)
            IDLE: begin
                // flushed or invalid requests are consumed immediately as drops
                skip_ack = skip_req && (pipe_flush || !w_req_valid);
            end
            DRAIN: begin
                skip_ack = pipe_flush;
            end
            REDIRECT: begin
                redirect_valid = !pipe_flush;
                flush_if_id    = w_taken;
                skip_ack       = pipe_flush || redirect_ready;
                skip_taken     = w_taken;
            end
            default: ;
        endcase
    end

    // Payload latch, held stable while the skip is in service
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_origin <= '0;
            r_target <= '0;
        end else if (w_accept) begin
            r_origin <= skip_origin;
            r_target <= skip_target;
        end
    end

    // Saturating skipped-instruction counter, bumped when a redirect is taken
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (w_taken) begin
            r_count <= w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
        end
    end

    assign redirect_pc = r_target;
    assign skip_count  = r_count;

endmodule

// File: tb/tb_sparce_skip_redirect.sv
// Directed bench for sparce_skip_redirect. Two instances share stimulus:
// a full-width one and a 4-bit-counter one for saturation behaviour.
module tb_sparce_skip_redirect;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        skip_req;
    logic [31:0] skip_origin;
    logic [31:0] skip_target;
    logic        imem_busy;
    logic        redirect_ready;
    logic        pipe_flush;

    logic        ack, taken, rv, fl;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        s_ack, s_taken, s_rv, s_fl;
    logic [31:0] s_pc;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sparce_skip_redirect #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) u_dut (
        .CLK(CLK), .nRST(nRST), .skip_req(skip_req), .skip_origin(skip_origin),
        .skip_target(skip_target), .imem_busy(imem_busy), .redirect_ready(redirect_ready),
        .pipe_flush(pipe_flush), .skip_ack(ack), .skip_taken(taken),
        .redirect_valid(rv), .redirect_pc(pc), .flush_if_id(fl), .skip_count(cnt)
    );

    sparce_skip_redirect #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) u_sat (
        .CLK(CLK), .nRST(nRST), .skip_req(skip_req), .skip_origin(skip_origin),
        .skip_target(skip_target), .imem_busy(imem_busy), .redirect_ready(redirect_ready),
        .pipe_flush(pipe_flush), .skip_ack(s_ack), .skip_taken(s_taken),
        .redirect_valid(s_rv), .redirect_pc(s_pc), .flush_if_id(s_fl), .skip_count(s_cnt)
    );

    // advance to just after the next rising edge
    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] o, input logic [31:0] t,
                         input logic busy, input logic rdy, input logic flsh);
        skip_req       = req;
        skip_origin    = o;
        skip_target    = t;
        imem_busy      = busy;
        redirect_ready = rdy;
        pipe_flush     = flsh;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        nRST = 1'b0;
        #12;
        nRST = 1'b1;
        next_cyc();
        @(negedge CLK);
        checks++;
        if ({ack, taken, rv, fl} !== 4'b0000 || pc !== 32'h0 || cnt !== 32'h0 || s_cnt !== 4'h0) begin
            errors++;
            $display("FAIL reset: ack/taken/rv/fl=%b pc=%h cnt=%0d scnt=%0d want 0000/0/0/0",
                     {ack, taken, rv, fl}, pc, cnt, s_cnt);
        end
    endtask

    task automatic test_basic();
        next_cyc();
        drive(1'b1, 32'h100, 32'h110, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        checks++;
        if ({ack, rv, fl} !== 3'b000) begin
            errors++;
            $display("FAIL basic_n: ack/rv/fl=%b want 000", {ack, rv, fl});
        end
        next_cyc();
        @(negedge CLK);
        checks++;
        if ({ack, taken, rv, fl} !== 4'b1111 || pc !== 32'h110) begin
            errors++;
            $display("FAIL basic_n1: ack/taken/rv/fl=%b pc=%h want 1111 pc=110", {ack, taken, rv, fl}, pc);
        end
        next_cyc();
        skip_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (cnt !== 32'd3 || s_cnt !== 4'd3 || rv !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: cnt=%0d scnt=%0d rv=%b want 3 3 0", cnt, s_cnt, rv);
        end
    endtask

    task automatic test_drain();
        logic early;
        early = 1'b0;
        next_cyc();
        drive(1'b1, 32'h100, 32'h110, 1'b1, 1'b1, 1'b0);
        // cycles N..N+3: busy for N..N+2, released at N+3
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_busy = 1'b0;
            @(negedge CLK);
            if (rv || fl || ack) early = 1'b1;
            next_cyc();
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL drain_early: redirect/flush/ack seen before N+4 got 1 want 0");
        end
        @(negedge CLK);
        checks++;
        if ({ack, taken, rv, fl} !== 4'b1111 || pc !== 32'h110) begin
            errors++;
            $display("FAIL drain_n4: ack/taken/rv/fl=%b pc=%h want 1111 pc=110", {ack, taken, rv, fl}, pc);
        end
        next_cyc();
        skip_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (cnt !== 32'd6 || s_cnt !== 4'd6) begin
            errors++;
            $display("FAIL drain_count: cnt=%0d scnt=%0d want 6 6", cnt, s_cnt);
        end
    endtask

    task automatic test_backpressure_flush();
        next_cyc();
        drive(1'b1, 32'h100, 32'h110, 1'b0, 1'b0, 1'b0);
        next_cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if ({ack, rv, fl} !== 3'b010 || pc !== 32'h110) begin
                errors++;
                $display("FAIL bp_hold%0d: ack/rv/fl=%b pc=%h want 010 pc=110", i, {ack, rv, fl}, pc);
            end
            next_cyc();
        end
        pipe_flush     = 1'b1;
        redirect_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if ({ack, taken, rv, fl} !== 4'b1000) begin
            errors++;
            $display("FAIL bp_flush: ack/taken/rv/fl=%b want 1000", {ack, taken, rv, fl});
        end
        next_cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        checks++;
        if (cnt !== 32'd6 || rv !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL bp_after: cnt=%0d rv=%b ack=%b want 6 0 0", cnt, rv, ack);
        end
    endtask

    task automatic test_reject();
        logic [31:0] tg [3];
        logic [2:0]  fl_in;
        tg[0] = 32'h102; tg[1] = 32'h104; tg[2] = 32'h110;
        fl_in = 3'b100;  // last case: valid request killed by pipe_flush in IDLE
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            drive(1'b1, 32'h100, tg[i], 1'b0, 1'b1, fl_in[i]);
            @(negedge CLK);
            checks++;
            if ({ack, taken, rv, fl} !== 4'b1000) begin
                errors++;
                $display("FAIL reject%0d: ack/taken/rv/fl=%b want 1000", i, {ack, taken, rv, fl});
            end
            next_cyc();
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            @(negedge CLK);
            checks++;
            if (rv !== 1'b0 || cnt !== 32'd6) begin
                errors++;
                $display("FAIL reject%0d_after: rv=%b cnt=%0d want 0 6", i, rv, cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        next_cyc();
        drive(1'b1, 32'h100, 32'h110, 1'b1, 1'b1, 1'b0);
        next_cyc();  // now in DRAIN
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if ({ack, taken, rv, fl} !== 4'b0000 || pc !== 32'h0 || cnt !== 32'h0 || s_cnt !== 4'h0) begin
            errors++;
            $display("FAIL arst: ack/taken/rv/fl=%b pc=%h cnt=%0d scnt=%0d want 0000/0/0/0",
                     {ack, taken, rv, fl}, pc, cnt, s_cnt);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        next_cyc();
        nRST = 1'b1;
        next_cyc();
        drive(1'b1, 32'h200, 32'h210, 1'b0, 1'b1, 1'b0);
        next_cyc();
        @(negedge CLK);
        checks++;
        if ({ack, taken, rv, fl} !== 4'b1111 || pc !== 32'h210) begin
            errors++;
            $display("FAIL arst_resume: ack/taken/rv/fl=%b pc=%h want 1111 pc=210", {ack, taken, rv, fl}, pc);
        end
        next_cyc();
        skip_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (cnt !== 32'd3 || s_cnt !== 4'd3) begin
            errors++;
            $display("FAIL arst_count: cnt=%0d scnt=%0d want 3 3", cnt, s_cnt);
        end
    endtask

    // best-case skip, no checks; used to walk the counters
    task automatic do_skip(input logic [31:0] o, input logic [31:0] t);
        next_cyc();
        drive(1'b1, o, t, 1'b0, 1'b1, 1'b0);
        next_cyc();
        next_cyc();
        skip_req = 1'b0;
    endtask

    task automatic test_saturation();
        // from 3: +3 +3 +3 +2 -> 14
        do_skip(32'h300, 32'h310);
        do_skip(32'h300, 32'h310);
        do_skip(32'h300, 32'h310);
        do_skip(32'h300, 32'h30C);
        @(negedge CLK);
        checks++;
        if (s_cnt !== 4'd14 || cnt !== 32'd14) begin
            errors++;
            $display("FAIL sat_14: scnt=%0d cnt=%0d want 14 14", s_cnt, cnt);
        end
        do_skip(32'h300, 32'h310);
        @(negedge CLK);
        checks++;
        if (s_cnt !== 4'd15 || cnt !== 32'd17) begin
            errors++;
            $display("FAIL sat_15: scnt=%0d cnt=%0d want 15 17", s_cnt, cnt);
        end
        do_skip(32'h300, 32'h310);
        @(negedge CLK);
        checks++;
        if (s_cnt !== 4'd15 || cnt !== 32'd20) begin
            errors++;
            $display("FAIL sat_hold: scnt=%0d cnt=%0d want 15 20", s_cnt, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_backpressure_flush();
        test_reject();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
